flash_prog: RTL and testbench
=============================

# flash_prog

Byte-wide program/erase controller for the parallel NOR flash that holds teletext pages (page n at byte address {2'b0, n[8:0], 10'b0}). The page renderer only ever reads this flash. This block is the write side of the same flash bus: it issues AMD-style unlock/command write cycles, then polls DQ7/DQ5 until the device finishes. The top level hands the flash pins to this block while `owns_bus` is high and to the teletext fetch path otherwise.

## Interface
- `WE_CYCLES`, default 3: width of the flash_we low pulse, in clk cycles (1..15).
- `RD_CYCLES`, default 3: width of the flash_oe low phase for a status read; the sample is taken on its last cycle (1..15).
- `POLL_LIMIT`, default 24'd16777215: maximum number of status reads per operation before a timeout error.

- `clk`  in  1  system clock (clk1x domain).
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only when busy=0.
- `erase`  in  1  0 = program byte, 1 = sector erase; sampled with start.
- `addr`  in  21  byte address, or any address inside the target sector; sampled with start.
- `wdata`  in  8  byte to program (ignored for erase); sampled with start.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse at operation end.
- `error`  out  1  result of the last operation; valid with done and held until the next accepted start.
- `owns_bus`  out  1  equals busy; the top level muxes the flash pins on it.
- `flash_ce`  out  1  chip enable, active low.
- `flash_oe`  out  1  output enable, active low.
- `flash_we`  out  1  write enable, active low.
- `flash_address`  out  21  flash byte address.
- `flash_dout`  out  8  write data.
- `flash_dout_en`  out  1  1 = drive flash_data with flash_dout.
- `flash_din`  in  8  flash_data as read from the pad.

## Operation
- Command sequences, each entry written as address<-data:
  - Program: AAA<-AA, 555<-55, AAA<-A0, addr<-wdata (4 writes).
  - Erase: AAA<-AA, 555<-55, AAA<-80, AAA<-AA, 555<-55, addr<-30 (6 writes).
- Unlock and command addresses are 21-bit zero-extended.
- A 3-bit step index walks through the sequence table.
- States:
  - IDLE: start latches erase/addr/wdata and moves to W_SETUP with step=0.
  - W_SETUP: 1 cycle.
  - W_PULSE: WE_CYCLES cycles.
  - W_HOLD: 1 cycle. After the last step go to P_READ; otherwise step+1 and back to W_SETUP.
  - P_READ: RD_CYCLES cycles; flash_din is captured on the last cycle.
  - P_GAP: 1 cycle, then evaluate the captured status:
    - DQ7 == expected (wdata[7] for program, 1 for erase): success, go to FIN.
    - DQ5 set on a first read: do one more read, the "confirm" read.
    - Confirm read still mismatches: error, go to FIN.
    - Poll count reaches POLL_LIMIT: error, go to FIN.
    - Otherwise read again.
  - FIN: done=1 for 1 cycle, then IDLE.
- Pin behaviour by state:
  - W_SETUP, W_PULSE, W_HOLD: flash_ce=0, flash_oe=1, flash_dout_en=1, address and data stable. flash_we=0 only in W_PULSE.
  - P_READ, P_GAP: flash_dout_en=0, flash_address=latched addr, flash_ce=0. flash_oe=0 only in P_READ.
- The poll counter is 24 bits, clears on start and increments per status read. It saturates and never wraps.
- start while busy is ignored: no latch, no effect.
- `erase` with an address inside a sector uses that address unchanged as the sector address.

## Timing
- Reset values (rst sampled high at a clk edge; outputs take these values from that edge):
  - flash_we=1, flash_oe=1, flash_ce=1, flash_dout_en=0, flash_address=0, flash_dout=0.
  - busy=0, done=0, error=0, owns_bus=0.
  - State IDLE, step=0, poll count=0.
- rst mid-operation: the same values from the next edge. This includes terminating a WE pulse early. No recovery of the interrupted flash command is attempted.
- Write cycle length is WE_CYCLES+2 clocks. With the default of 3 that is 5 clocks:
  - Program: 20 clocks of writes.
  - Erase: 30 clocks of writes.
- Status read length is RD_CYCLES+1 clocks.
- busy rises on the edge after start is sampled and falls on the edge after the done cycle.
- Back-to-back: start in the cycle right after busy falls is accepted.
- Address, data and CE are held constant across the WE rising edge. W_HOLD provides the hold time.
- Minimum program latency (start to done), defaults, DQ7 matching on the first read: 20 + 4 + 1 = 25 clocks.

## Test plan
- Program 0x5A at 0x04C00 with a flash model that reports success on the 3rd read:
  - Write cycles observed: (AAA,AA), (555,55), (AAA,A0), (04C00,5A), each with a 3-clock WE pulse.
  - 3 reads at 04C00, then done with error=0.
  - Total busy time 20 + 3×4 + 1 = 33 clocks.
- Erase sector at 0x10000:
  - 6 write cycles in table order, ending (10000,30).
  - Model returns DQ7=0 for 5 reads, then 1: done with error=0.
- Program 0x80; model holds DQ7=0 with DQ5=1: one confirm read follows, then done with error=1 after exactly 2 reads.
- Timeout: POLL_LIMIT=4, model never completes → exactly 4 reads, then error=1.
- Pulse start while busy with a different addr → the first operation completes unchanged and no second operation starts.
- Assert rst during the 2nd cycle of the 3rd W_PULSE → next edge shows flash_we=1, flash_ce=1, busy=0, flash_dout_en=0. A fresh start then runs normally from step 0.

Source files
------------

// File: rtl/flash_prog_if.sv
// flash_prog_if
// Request/status handshake and flash pad signals of the flash program/erase
// controller, bundled so the controller, the top level and the bench share
// one definition.
//   start/erase/addr/wdata : operation request, sampled while busy is low
//   busy/done/error        : operation status
//   owns_bus               : high while the controller drives the flash pins
//   flash_ce/oe/we         : active-low flash strobes
//   flash_address          : flash byte address
//   flash_dout/_en         : write data and its pad drive enable
//   flash_din              : data read back from the flash pad
// modport slave is the controller side, modport master the requester/pad side.

interface flash_prog_if;
  logic        start;
  logic        erase;
  logic [20:0] addr;
  logic [7:0]  wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        owns_bus;
  logic        flash_ce;
  logic        flash_oe;
  logic        flash_we;
  logic [20:0] flash_address;
  logic [7:0]  flash_dout;
  logic        flash_dout_en;
  logic [7:0]  flash_din;

  modport slave (
    input  start, erase, addr, wdata, flash_din,
    output busy, done, error, owns_bus,
    output flash_ce, flash_oe, flash_we, flash_address, flash_dout, flash_dout_en
  );

  modport master (
    output start, erase, addr, wdata, flash_din,
    input  busy, done, error, owns_bus,
    input  flash_ce, flash_oe, flash_we, flash_address, flash_dout, flash_dout_en
  );
endinterface

// File: rtl/flash_prog.sv
// flash_prog
// Write side of the teletext NOR flash bus. Issues the AMD-style unlock and
// command write cycles for a byte program or a sector erase, then polls the
// status byte (DQ7 data polling, DQ5 exceeded-timing flag) until the device
// reports completion, a confirmed failure, or the poll budget runs out.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : flash_prog_if.slave (request handshake, status and flash pins)
// Parameters:
//   WE_CYCLES  : flash_we low pulse width in clocks (1..15)
//   RD_CYCLES  : flash_oe low phase of a status read in clocks (1..15)
//   POLL_LIMIT : maximum status reads per operation before a timeout error

module flash_prog #(
  parameter int unsigned WE_CYCLES  = 3,
  parameter int unsigned RD_CYCLES  = 3,
  parameter logic [23:0] POLL_LIMIT = 24'd16777215
) (
  input  logic         clk,
  input  logic         rst,
  flash_prog_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_SETUP,
    S_W_PULSE,
    S_W_HOLD,
    S_P_READ,
    S_P_GAP,
    S_FIN
  } state_t;

  localparam logic [3:0]  WE_LAST  = 4'(WE_CYCLES - 1);
  localparam logic [3:0]  RD_LAST  = 4'(RD_CYCLES - 1);
  localparam logic [23:0] POLL_MAX = 24'hFFFFFF;

  // Command sequence table: address for each step of program or erase.
  // The final step carries the user address (byte or sector).
  function automatic logic [20:0] seq_addr(input logic [2:0]  step,
                                           input logic        is_erase,
                                           input logic [20:0] target);
    logic [20:0] a;
    a = 21'h000AAA;
    if (is_erase) begin
      case (step)
        3'd1, 3'd4: a = 21'h000555;
        3'd5:       a = target;
        default:    a = 21'h000AAA;
      endcase
    end else begin
      case (step)
        3'd1:    a = 21'h000555;
        3'd3:    a = target;
        default: a = 21'h000AAA;
      endcase
    end
    return a;
  endfunction

  // Command sequence table: data byte for each step.
  function automatic logic [7:0] seq_data(input logic [2:0] step,
                                          input logic       is_erase,
                                          input logic [7:0] byte_in);
    logic [7:0] d;
    d = 8'hAA;
    if (is_erase) begin
      case (step)
        3'd1, 3'd4: d = 8'h55;
        3'd2:       d = 8'h80;
        3'd5:       d = 8'h30;
        default:    d = 8'hAA;
      endcase
    end else begin
      case (step)
        3'd1:    d = 8'h55;
        3'd2:    d = 8'hA0;
        3'd3:    d = byte_in;
        default: d = 8'hAA;
      endcase
    end
    return d;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [23:0] poll_q, poll_d;
  logic        confirm_q, confirm_d;
  logic        erase_q, erase_d;
  logic [20:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  status_q, status_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        ce_q, ce_d;
  logic        oe_q, oe_d;
  logic        we_q, we_d;
  logic        dout_en_q, dout_en_d;
  logic [20:0] faddr_q, faddr_d;
  logic [7:0]  fdout_q, fdout_d;

  logic [2:0]  last_step;
  logic        want_dq7;

  // Erase writes six command cycles, program four. Data polling compares
  // DQ7 against the final value: the programmed bit, or 1 for erased cells.
  always_comb begin
    last_step = erase_q ? 3'd5 : 3'd3;
    want_dq7  = erase_q ? 1'b1 : wdata_q[7];
  end

  // Next-state logic. The pin values are derived from the next state so
  // every flash strobe comes straight out of a flop and changes on the same
  // edge as the state it belongs to.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    poll_d    = poll_q;
    confirm_d = confirm_q;
    erase_d   = erase_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    status_d  = status_q;
    error_d   = error_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          erase_d   = bus.erase;
          addr_d    = bus.addr;
          wdata_d   = bus.wdata;
          step_d    = 3'd0;
          cnt_d     = 4'd0;
          poll_d    = 24'd0;
          confirm_d = 1'b0;
          error_d   = 1'b0;
          state_d   = S_W_SETUP;
        end
      end

      S_W_SETUP: begin
        cnt_d   = 4'd0;
        state_d = S_W_PULSE;
      end

      S_W_PULSE: begin
        if (cnt_q == WE_LAST) begin
          state_d = S_W_HOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_W_HOLD: begin
        cnt_d = 4'd0;
        if (step_q == last_step) begin
          state_d = S_P_READ;
        end else begin
          step_d  = step_q + 3'd1;
          state_d = S_W_SETUP;
        end
      end

      S_P_READ: begin
        if (cnt_q == RD_LAST) begin
          status_d = bus.flash_din;
          if (poll_q != POLL_MAX) begin
            poll_d = poll_q + 24'd1;
          end
          state_d = S_P_GAP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      // A DQ5 flag only arms one confirm read; the timeout check comes first
      // so the read count never exceeds POLL_LIMIT.
      S_P_GAP: begin
        cnt_d = 4'd0;
        if (status_q[7] == want_dq7) begin
          state_d = S_FIN;
        end else if (confirm_q || (poll_q >= POLL_LIMIT)) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end else begin
          confirm_d = status_q[5];
          state_d   = S_P_READ;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);

    ce_d      = 1'b1;
    oe_d      = 1'b1;
    we_d      = 1'b1;
    dout_en_d = 1'b0;
    faddr_d   = faddr_q;
    fdout_d   = fdout_q;

    case (state_d)
      S_W_SETUP, S_W_PULSE, S_W_HOLD: begin
        ce_d      = 1'b0;
        dout_en_d = 1'b1;
        we_d      = (state_d != S_W_PULSE);
        faddr_d   = seq_addr(step_d, erase_d, addr_d);
        fdout_d   = seq_data(step_d, erase_d, wdata_d);
      end
      S_P_READ, S_P_GAP: begin
        ce_d    = 1'b0;
        oe_d    = (state_d != S_P_READ);
        faddr_d = addr_d;
      end
      default: begin
      end
    endcase
  end

  // State and output registers; reset also aborts any WE pulse in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      step_q    <= 3'd0;
      cnt_q     <= 4'd0;
      poll_q    <= 24'd0;
      confirm_q <= 1'b0;
      erase_q   <= 1'b0;
      addr_q    <= 21'd0;
      wdata_q   <= 8'd0;
      status_q  <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      ce_q      <= 1'b1;
      oe_q      <= 1'b1;
      we_q      <= 1'b1;
      dout_en_q <= 1'b0;
      faddr_q   <= 21'd0;
      fdout_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      poll_q    <= poll_d;
      confirm_q <= confirm_d;
      erase_q   <= erase_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      status_q  <= status_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      ce_q      <= ce_d;
      oe_q      <= oe_d;
      we_q      <= we_d;
      dout_en_q <= dout_en_d;
      faddr_q   <= faddr_d;
      fdout_q   <= fdout_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.owns_bus      = busy_q;
  assign bus.done          = done_q;
  assign bus.error         = error_q;
  assign bus.flash_ce      = ce_q;
  assign bus.flash_oe      = oe_q;
  assign bus.flash_we      = we_q;
  assign bus.flash_dout_en = dout_en_q;
  assign bus.flash_address = faddr_q;
  assign bus.flash_dout    = fdout_q;

endmodule

// File: tb/tb_flash_prog.sv
// tb_flash_prog
// Bench for flash_prog. A reference trace of every cycle of an operation is
// built from the command tables and the polling rules, then checked against
// the DUT on each falling edge. A second instance with a small poll limit
// covers the timeout path.

module tb_flash_prog;

  localparam int WE_C = 3;
  localparam int RD_C = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  flash_prog_if bus ();
  flash_prog_if bus_t ();

  flash_prog #(.WE_CYCLES(WE_C), .RD_CYCLES(RD_C), .POLL_LIMIT(24'd16777215)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  flash_prog #(.WE_CYCLES(WE_C), .RD_CYCLES(RD_C), .POLL_LIMIT(24'd4)) dut_t (
    .clk (clk),
    .rst (rst),
    .bus (bus_t)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        chk_err;
    logic        err;
    logic        chk_pins;
    logic        ce;
    logic        oe;
    logic        we;
    logic        den;
    logic [20:0] fa;
    logic [7:0]  fd;
  } exp_t;

  exp_t exp_q[$];

  // Flash model: status byte returned for read number k is resp[k].
  logic [7:0]  resp [16];
  int          rd_count = 0;
  int          busy_cycles = 0;
  logic        oe_prev = 1'b1;
  logic        we_prev = 1'b1;
  logic [20:0] wlog_a[$];
  logic [7:0]  wlog_d[$];
  int          t_reads = 0;
  logic        t_oe_prev = 1'b1;

  always_comb begin
    if (rd_count > 15) bus.flash_din = resp[15];
    else               bus.flash_din = resp[rd_count[3:0]];
  end

  assign bus_t.flash_din = 8'h00;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Observe the flash side: count reads, log write cycles, count busy time.
  always @(negedge clk) begin
    if (!oe_prev && bus.flash_oe) rd_count++;
    if (!we_prev && bus.flash_we) begin
      wlog_a.push_back(bus.flash_address);
      wlog_d.push_back(bus.flash_dout);
    end
    if (bus.busy) busy_cycles++;
    oe_prev = bus.flash_oe;
    we_prev = bus.flash_we;
    if (!t_oe_prev && bus_t.flash_oe) t_reads++;
    t_oe_prev = bus_t.flash_oe;
  end

  // Compare process: one reference entry per cycle while a trace is queued.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("busy_done_owns", 64'({bus.busy, bus.done, bus.owns_bus}),
                  64'({e.busy, e.done, e.busy}));
      if (e.chk_err) checkOutput("error", 64'(bus.error), 64'(e.err));
      if (e.chk_pins)
        checkOutput("pins",
          64'({bus.flash_ce, bus.flash_oe, bus.flash_we, bus.flash_dout_en,
               bus.flash_address, (e.den ? bus.flash_dout : 8'h00)}),
          64'({e.ce, e.oe, e.we, e.den, e.fa, (e.den ? e.fd : 8'h00)}));
    end
  end

  // Number of status reads and the final error flag, from the polling rules.
  function automatic int modelReads(input logic is_erase, input logic [7:0] wd,
                                    input int limit, output logic err);
    logic       want;
    logic       confirm;
    logic [7:0] st;
    want    = is_erase ? 1'b1 : wd[7];
    confirm = 1'b0;
    err     = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      st = resp[(i > 15) ? 15 : i];
      if (st[7] == want) begin
        err = 1'b0;
        return i + 1;
      end
      if (confirm || (i + 1) >= limit) begin
        err = 1'b1;
        return i + 1;
      end
      confirm = st[5];
    end
    return 4096;
  endfunction

  task automatic pushCycle(input logic busy, input logic done, input logic chk_err,
                           input logic err, input logic chk_pins, input logic ce,
                           input logic oe, input logic we, input logic den,
                           input logic [20:0] fa, input logic [7:0] fd);
    exp_t e;
    e.busy = busy; e.done = done; e.chk_err = chk_err; e.err = err;
    e.chk_pins = chk_pins; e.ce = ce; e.oe = oe; e.we = we; e.den = den;
    e.fa = fa; e.fd = fd;
    exp_q.push_back(e);
  endtask

  // Reference trace: each write is setup + WE pulse + hold, each read is the
  // OE phase + gap, then one done cycle and idle_n idle cycles.
  task automatic buildTrace(input logic is_erase, input logic [20:0] a, input logic [7:0] wd,
                            input int n_reads, input logic err, input int idle_n);
    logic [20:0] wa [6];
    logic [7:0]  wdat [6];
    int          nw;
    if (is_erase) begin
      wa   = '{21'hAAA, 21'h555, 21'hAAA, 21'hAAA, 21'h555, a};
      wdat = '{8'hAA, 8'h55, 8'h80, 8'hAA, 8'h55, 8'h30};
      nw   = 6;
    end else begin
      wa   = '{21'hAAA, 21'h555, 21'hAAA, a, 21'h0, 21'h0};
      wdat = '{8'hAA, 8'h55, 8'hA0, wd, 8'h00, 8'h00};
      nw   = 4;
    end
    for (int i = 0; i < nw; i++) begin
      pushCycle(1, 0, 0, 0, 1, 0, 1, 1, 1, wa[i], wdat[i]);
      for (int k = 0; k < WE_C; k++) pushCycle(1, 0, 0, 0, 1, 0, 1, 0, 1, wa[i], wdat[i]);
      pushCycle(1, 0, 0, 0, 1, 0, 1, 1, 1, wa[i], wdat[i]);
    end
    for (int r = 0; r < n_reads; r++) begin
      for (int k = 0; k < RD_C; k++) pushCycle(1, 0, 0, 0, 1, 0, 0, 1, 0, a, 8'h00);
      pushCycle(1, 0, 0, 0, 1, 0, 1, 1, 0, a, 8'h00);
    end
    pushCycle(1, 1, 1, err, 0, 1, 1, 1, 0, 21'h0, 8'h00);
    for (int k = 0; k < idle_n; k++) pushCycle(0, 0, 1, err, 0, 1, 1, 1, 0, 21'h0, 8'h00);
  endtask

  task automatic applyStimulus(input logic is_erase, input logic [20:0] a, input logic [7:0] wd,
                               input bit interfere, input int idle_n,
                               output int n_model, output logic err_model);
    int guard;
    n_model = modelReads(is_erase, wd, 16777215, err_model);
    @(negedge clk);
    wlog_a.delete();
    wlog_d.delete();
    rd_count    = 0;
    busy_cycles = 0;
    bus.start = 1'b1;
    bus.erase = is_erase;
    bus.addr  = a;
    bus.wdata = wd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.erase = ~is_erase;
    bus.addr  = 21'h1ABCD;
    bus.wdata = 8'hFF;
    buildTrace(is_erase, a, wd, n_model, err_model, idle_n);
    if (interfere) begin
      repeat (8) @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.erase = 1'b1;
      bus.addr  = 21'h1F000;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    checkOutput("trace_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int          n;
    int          guard;
    logic        err;
    logic [28:0] lit [6];

    rst = 1'b1;
    bus.start = 1'b0;   bus.erase = 1'b0;   bus.addr = 21'h0;   bus.wdata = 8'h0;
    bus_t.start = 1'b0; bus_t.erase = 1'b0; bus_t.addr = 21'h0; bus_t.wdata = 8'h0;
    for (int i = 0; i < 16; i++) resp[i] = 8'h00;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_status", 64'({bus.busy, bus.done, bus.error, bus.owns_bus}), 64'd0);
    checkOutput("reset_pins", 64'({bus.flash_ce, bus.flash_oe, bus.flash_we, bus.flash_dout_en,
                bus.flash_address, bus.flash_dout}), 64'({4'b1110, 21'h0, 8'h00}));
    checkOutput("reset_t_status", 64'({bus_t.busy, bus_t.done, bus_t.error}), 64'd0);
    rst = 1'b0;

    // Program 0x5A at 0x04C00, success on the third read
    for (int i = 0; i < 16; i++) resp[i] = (i < 2) ? 8'h80 : 8'h5A;
    applyStimulus(1'b0, 21'h04C00, 8'h5A, 1'b0, 2, n, err);
    checkOutput("t1_model_reads", 64'(n), 64'd3);
    checkOutput("t1_reads_seen", 64'(rd_count), 64'd3);
    checkOutput("t1_busy_cycles", 64'(busy_cycles), 64'd33);
    checkOutput("t1_error", 64'(bus.error), 64'd0);
    lit[0] = {21'hAAA, 8'hAA}; lit[1] = {21'h555, 8'h55};
    lit[2] = {21'hAAA, 8'hA0}; lit[3] = {21'h04C00, 8'h5A};
    checkOutput("t1_write_count", 64'(wlog_a.size()), 64'd4);
    for (int i = 0; i < 4 && i < wlog_a.size(); i++)
      checkOutput("t1_write_cycle", 64'({wlog_a[i], wlog_d[i]}), 64'(lit[i]));

    // Sector erase at 0x10000, DQ7 low for five reads
    for (int i = 0; i < 16; i++) resp[i] = (i < 5) ? 8'h00 : 8'h80;
    applyStimulus(1'b1, 21'h10000, 8'h00, 1'b0, 2, n, err);
    checkOutput("t2_model_reads", 64'(n), 64'd6);
    checkOutput("t2_reads_seen", 64'(rd_count), 64'd6);
    checkOutput("t2_busy_cycles", 64'(busy_cycles), 64'd55);
    checkOutput("t2_error", 64'(bus.error), 64'd0);
    lit[0] = {21'hAAA, 8'hAA}; lit[1] = {21'h555, 8'h55}; lit[2] = {21'hAAA, 8'h80};
    lit[3] = {21'hAAA, 8'hAA}; lit[4] = {21'h555, 8'h55}; lit[5] = {21'h10000, 8'h30};
    checkOutput("t2_write_count", 64'(wlog_a.size()), 64'd6);
    for (int i = 0; i < 6 && i < wlog_a.size(); i++)
      checkOutput("t2_write_cycle", 64'({wlog_a[i], wlog_d[i]}), 64'(lit[i]));

    // Program 0x80 with DQ7=0, DQ5=1: one confirm read then error
    for (int i = 0; i < 16; i++) resp[i] = 8'h20;
    applyStimulus(1'b0, 21'h00200, 8'h80, 1'b0, 2, n, err);
    checkOutput("t3_model_reads", 64'(n), 64'd2);
    checkOutput("t3_model_err", 64'(err), 64'd1);
    checkOutput("t3_reads_seen", 64'(rd_count), 64'd2);
    checkOutput("t3_error", 64'(bus.error), 64'd1);

    // start while busy must be ignored
    for (int i = 0; i < 16; i++) resp[i] = 8'h33;
    applyStimulus(1'b0, 21'h00400, 8'h33, 1'b1, 4, n, err);
    checkOutput("t4_write_count", 64'(wlog_a.size()), 64'd4);
    if (wlog_a.size() > 0)
      checkOutput("t4_last_write", 64'({wlog_a[wlog_a.size()-1], wlog_d[wlog_d.size()-1]}),
                  64'({21'h00400, 8'h33}));
    checkOutput("t4_reads_seen", 64'(rd_count), 64'd1);
    checkOutput("t4_busy_cycles", 64'(busy_cycles), 64'd25);

    // Back-to-back: second start in the cycle right after busy falls
    for (int i = 0; i < 16; i++) resp[i] = 8'h00;
    applyStimulus(1'b0, 21'h00001, 8'h01, 1'b0, 0, n, err);
    checkOutput("t5a_busy_cycles", 64'(busy_cycles), 64'd25);
    applyStimulus(1'b0, 21'h00002, 8'h02, 1'b0, 2, n, err);
    checkOutput("t5b_busy_cycles", 64'(busy_cycles), 64'd25);
    if (wlog_a.size() > 0)
      checkOutput("t5b_last_write", 64'({wlog_a[wlog_a.size()-1], wlog_d[wlog_d.size()-1]}),
                  64'({21'h00002, 8'h02}));

    // Reset during the second cycle of the third WE pulse
    @(negedge clk);
    bus.start = 1'b1; bus.erase = 1'b0; bus.addr = 21'h00800; bus.wdata = 8'h77;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    buildTrace(1'b0, 21'h00800, 8'h77, 1, 1'b0, 0);
    while (exp_q.size() > 13) exp_q.delete(exp_q.size() - 1);
    repeat (12) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_queue", 64'(exp_q.size()), 64'd0);
    checkOutput("rst_we", 64'(bus.flash_we), 64'd1);
    checkOutput("rst_ce", 64'(bus.flash_ce), 64'd1);
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_dout_en", 64'(bus.flash_dout_en), 64'd0);
    checkOutput("rst_rest", 64'({bus.flash_oe, bus.done, bus.error, bus.owns_bus,
                bus.flash_address, bus.flash_dout}), 64'({4'b1000, 21'h0, 8'h00}));
    applyStimulus(1'b0, 21'h00800, 8'h77, 1'b0, 2, n, err);
    checkOutput("t6_write_count", 64'(wlog_a.size()), 64'd4);
    if (wlog_a.size() > 0)
      checkOutput("t6_first_write", 64'({wlog_a[0], wlog_d[0]}), 64'({21'hAAA, 8'hAA}));
    checkOutput("t6_reads_seen", 64'(rd_count), 64'd1);

    // Timeout on the instance with POLL_LIMIT=4
    for (int i = 0; i < 16; i++) resp[i] = 8'h00;
    n = modelReads(1'b0, 8'h80, 4, err);
    checkOutput("t7_model_reads", 64'(n), 64'd4);
    checkOutput("t7_model_err", 64'(err), 64'd1);
    @(negedge clk);
    t_reads = 0;
    bus_t.start = 1'b1; bus_t.erase = 1'b0; bus_t.addr = 21'h00100; bus_t.wdata = 8'h80;
    @(posedge clk);
    #1 bus_t.start = 1'b0;
    guard = 0;
    while (!bus_t.done && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("t7_done_seen", 64'(bus_t.done), 64'd1);
    checkOutput("t7_reads_seen", 64'(t_reads), 64'(n));
    checkOutput("t7_error", 64'(bus_t.error), 64'd1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
